fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with valid/ready
//  handshake on both sides and sticky-free per-result exception flags. Defaults to binary16.
//  Datapath feeds the MAC accumulator; replaces single-cycle combinational fp16 multiply.
//  Round-to-nearest-even via guard/round/sticky; subnormals flushed to zero (in and out).
// PARAMETERS
//  EXP_W   5    exponent field width (bias = 2**(EXP_W-1)-1)
//  MAN_W   10   stored fraction width (hidden bit implicit); word width W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    operand pair valid
//  in_ready   out  1    pipeline can accept operands this cycle
//  in_a       in   W    operand A
//  in_b       in   W    operand B
//  out_valid  out  1    result valid
//  out_ready  in   1    downstream accepts result
//  out_data   out  W    product
//  out_flags  out  4    {invalid, overflow, underflow, inexact} for out_data
// BEHAVIOUR
//  Reset (async assert, sync release): all stage valids 0; out_valid=0, out_data=0, out_flags=0.
//  Reset mid-operation discards all in-flight results; no partial output afterwards.
//  Transfer in on in_valid&in_ready; out on out_valid&out_ready. out_data/flags stable while
//  out_valid&!out_ready. Latency 3 cycles accept->out_valid; throughput 1/cycle if out_ready=1.
//  Stage k advances when stage k+1 empty or advancing (bubbles collapse); in_ready=!v1|adv1,
//  combinational from out_ready. Max 3 results in flight; order preserved, none dropped/duplicated.
//  S1: sign=a.s^b.s; classify (zero: exp==0 incl. subnormal; inf; NaN); exp_sum=ea+eb-bias,
//      EXP_W+2 bits signed; (MAN_W+1)x(MAN_W+1) mantissa product, 2*MAN_W+2 bits.
//  S2: if product MSB set: shift right 1, exp_sum+1. Extract MAN_W fraction, guard, round,
//      sticky = OR of remaining low bits.
//  S3: round-up = G & (R|S|LSB); carry out of rounding renormalises (exp+1, fraction=0).
//      Biased exp >= 2**EXP_W-1 -> +/-inf, overflow=1, inexact=1.
//      Biased exp <= 0 -> signed zero, underflow=1, inexact=1.
//      inexact = G|R|S otherwise.
//  Specials (priority order, override arithmetic, no other flags):
//      NaN operand -> canonical qNaN (sign 0, exp all 1s, frac MSB only).
//      inf*zero -> qNaN, invalid=1.
//      inf*finite -> signed inf.
//      zero*finite -> signed zero.
//  Simultaneous in/out transfer when full: allowed, occupancy unchanged.
// TESTING
//  1) 0x3C00*0x3C00 -> 0x3C00 flags 0; 0x3E00*0x4000 -> 0x4200; 0xC000*0x3800 -> 0xBC00;
//     each out_valid exactly 3 cycles after accept.
//  2) 0x3C01*0x3E00 (exact tie, odd LSB) -> 0x3E02, inexact=1; 0x3C01*0x3C01 -> 0x3C02, inexact=1.
//  3) 0x7BFF*0x4000 -> 0x7C00, flags 4'b0101; 0x0400*0x3800 -> 0x0000, flags 4'b0011;
//     0x8400*0x3800 -> 0x8000, flags 4'b0011.
//  4) 0x7C00*0x0000 -> 0x7E00, flags 4'b1000; 0x7E00*0x3C00 -> 0x7E00, flags 0;
//     0xFC00*0x4000 -> 0xFC00, flags 0.
//  5) out_ready=0, stream 5 pairs: exactly 3 accepted then in_ready=0; out_data held constant.
//     Release out_ready: all 5 results emerge in order, 1/cycle.
//  6) Assert rst_n=0 with 3 in flight: out_valid=0, out_data=0 immediately; after release,
//     no stale output and a new op returns after 3 cycles.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined floating-point multiplier, valid/ready on both sides.
// Round-to-nearest-even, subnormals flushed to zero on input and output.
module fp_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic [3:0]             out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW2  = EXP_W + 2;
  localparam int P    = 2 * MAN_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX = 2 ** EXP_W - 1;

  localparam logic [2:0] SP_NONE = 3'd0;
  localparam logic [2:0] SP_NAN  = 3'd1;
  localparam logic [2:0] SP_INV  = 3'd2;
  localparam logic [2:0] SP_INF  = 3'd3;
  localparam logic [2:0] SP_ZERO = 3'd4;

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic w_en1, w_en2, w_en3;
  logic r_v1, r_v2, r_v3;

  // Bubbles collapse: a stage loads whenever the next one frees up.
  assign w_en3    = !r_v3 | out_ready;
  assign w_en2    = !r_v2 | w_en3;
  assign w_en1    = !r_v1 | w_en2;
  assign in_ready = w_en1;

  // ---------------- S1: classify, exponent sum, mantissa product
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_az, w_bz, w_ai, w_bi, w_an, w_bn;
  logic [2:0]       w_sp1;
  logic [EW2-1:0]   w_exp1;
  logic [P-1:0]     w_prod;

  assign w_ea = in_a[W-2 -: EXP_W];
  assign w_eb = in_b[W-2 -: EXP_W];
  assign w_fa = in_a[MAN_W-1:0];
  assign w_fb = in_b[MAN_W-1:0];
  assign w_az = (w_ea == '0);
  assign w_bz = (w_eb == '0);
  assign w_ai = (&w_ea) & ~(|w_fa);
  assign w_bi = (&w_eb) & ~(|w_fb);
  assign w_an = (&w_ea) & (|w_fa);
  assign w_bn = (&w_eb) & (|w_fb);

  always_comb begin
    w_sp1 = SP_NONE;
    if (w_an | w_bn)
      w_sp1 = SP_NAN;
    else if ((w_ai & w_bz) | (w_az & w_bi))
      w_sp1 = SP_INV;
    else if (w_ai | w_bi)
      w_sp1 = SP_INF;
    else if (w_az | w_bz)
      w_sp1 = SP_ZERO;
  end

  assign w_exp1 = EW2'({2'b00, w_ea}) + EW2'({2'b00, w_eb}) - EW2'(BIAS);
  assign w_prod = P'({1'b1, w_fa}) * P'({1'b1, w_fb});

  logic           r_s1_sign;
  logic [2:0]     r_s1_sp;
  logic [EW2-1:0] r_s1_exp;
  logic [P-1:0]   r_s1_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_sp   <= SP_NONE;
      r_s1_exp  <= '0;
      r_s1_prod <= '0;
    end else if (w_en1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_a[W-1] ^ in_b[W-1];
        r_s1_sp   <= w_sp1;
        r_s1_exp  <= w_exp1;
        r_s1_prod <= w_prod;
      end
    end
  end

  // ---------------- S2: normalise, extract fraction and G/R/S
  logic           w_msb;
  logic [P-1:0]   w_norm;
  logic [EW2-1:0] w_exp2;

  assign w_msb  = r_s1_prod[P-1];
  assign w_norm = w_msb ? r_s1_prod : {r_s1_prod[P-2:0], 1'b0};
  assign w_exp2 = r_s1_exp + EW2'(w_msb);

  logic             r_s2_sign;
  logic [2:0]       r_s2_sp;
  logic [EW2-1:0]   r_s2_exp;
  logic [MAN_W-1:0] r_s2_frac;
  logic             r_s2_g, r_s2_r, r_s2_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2      <= 1'b0;
      r_s2_sign <= 1'b0;
      r_s2_sp   <= SP_NONE;
      r_s2_exp  <= '0;
      r_s2_frac <= '0;
      r_s2_g    <= 1'b0;
      r_s2_r    <= 1'b0;
      r_s2_s    <= 1'b0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_s2_sign <= r_s1_sign;
        r_s2_sp   <= r_s1_sp;
        r_s2_exp  <= w_exp2;
        r_s2_frac <= w_norm[P-2 -: MAN_W];
        r_s2_g    <= w_norm[P-2-MAN_W];
        r_s2_r    <= w_norm[P-3-MAN_W];
        r_s2_s    <= |w_norm[P-4-MAN_W:0];
      end
    end
  end

  // ---------------- S3: round, range check, specials
  logic             w_rup, w_carry, w_ovf, w_unf, w_inx;
  logic [MAN_W-1:0] w_frac3;
  logic [EW2-1:0]   w_exp3;
  logic [W-1:0]     w_res;
  logic [3:0]       w_flg;

  assign w_rup = r_s2_g & (r_s2_r | r_s2_s | r_s2_frac[0]);
  assign {w_carry, w_frac3} = {1'b0, r_s2_frac} + (MAN_W+1)'(w_rup);
  assign w_exp3 = r_s2_exp + EW2'(w_carry);
  assign w_ovf  = !w_exp3[EW2-1] & (w_exp3 >= EW2'(EMAX));
  assign w_unf  = w_exp3[EW2-1] | (w_exp3 == '0);
  assign w_inx  = r_s2_g | r_s2_r | r_s2_s;

  always_comb begin
    w_res = {r_s2_sign, w_exp3[EXP_W-1:0], w_frac3};
    w_flg = {3'b000, w_inx};
    unique case (r_s2_sp)
      SP_NAN: begin
        w_res = QNAN;
        w_flg = 4'b0000;
      end
      SP_INV: begin
        w_res = QNAN;
        w_flg = 4'b1000;
      end
      SP_INF: begin
        w_res = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_flg = 4'b0000;
      end
      SP_ZERO: begin
        w_res = {r_s2_sign, {(W-1){1'b0}}};
        w_flg = 4'b0000;
      end
      default: begin
        if (w_ovf) begin
          w_res = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_flg = 4'b0101;
        end else if (w_unf) begin
          w_res = {r_s2_sign, {(W-1){1'b0}}};
          w_flg = 4'b0011;
        end
      end
    endcase
  end

  logic [W-1:0] r_data;
  logic [3:0]   r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3    <= 1'b0;
      r_data  <= '0;
      r_flags <= '0;
    end else if (w_en3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_data  <= w_res;
        r_flags <= w_flg;
      end
    end
  end

  assign out_valid = r_v3;
  assign out_data  = r_data;
  assign out_flags = r_flags;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (binary16): directed, stall,
// reset-flush and random traffic against a reference model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_flags;

  fp_mul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  f;
    int          acc;
    bit          lat;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  mon_en = 1'b1;
  bit  rnd_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: integer product, remainder-vs-half rounding.
  function automatic logic [19:0] model(input logic [15:0] a,
                                        input logic [15:0] b);
    int ea, eb, fa, fb, m, e, sh, q, rem, half;
    bit s, an, bn, ai, bi, az, bz, inx;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
    ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
    az = (ea == 0);               bz = (eb == 0);
    if (an || bn) return {4'b0000, 16'h7E00};
    if ((ai && bz) || (az && bi)) return {4'b1000, 16'h7E00};
    if (ai || bi) return {4'b0000, s, 15'h7C00};
    if (az || bz) return {4'b0000, s, 15'h0000};
    m = (1024 + fa) * (1024 + fb);
    e = ea + eb - 15;
    if (m >= (1 << 21)) begin sh = 11; e++; end
    else sh = 10;
    q    = m >> sh;
    rem  = m & ((1 << sh) - 1);
    half = 1 << (sh - 1);
    inx  = (rem != 0);
    if (rem > half || (rem == half && (q % 2) == 1)) q++;
    if (q == 2048) begin q = 1024; e++; end
    if (e >= 31) return {4'b0101, s, 15'h7C00};
    if (e <= 0)  return {4'b0011, s, 15'h0000};
    return {3'b000, inx, s, 5'(e), 10'(q)};
  endfunction

  task automatic sb_push(input logic [15:0] d, input logic [3:0] f,
                         input bit lat);
    sb_t e;
    e.d = d; e.f = f; e.acc = cyc; e.lat = lat;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (rst_n && mon_en && out_valid) begin
      if (sb.size() == 0)
        check("spurious", 1, 0);
      else if (out_ready) begin
        e = sb.pop_front();
        check("data", out_data, e.d);
        check("flags", out_flags, e.f);
        if (e.lat) check("latency", cyc - e.acc, 3);
      end else
        check("hold", out_data, sb[0].d);
    end
  end

  always @(posedge clk)
    if (rnd_bp) begin
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ed, input logic [3:0] ef,
                       input bit lat);
    bit done;
    done = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_push(ed, ef, lat);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
  endtask

  logic [15:0] p5a [5] = '{16'h3C00, 16'h4200, 16'h3555, 16'hBC00, 16'h5000};
  logic [15:0] p5b [5] = '{16'h4000, 16'h4200, 16'h3555, 16'h3C00, 16'h2000};

  initial begin
    logic [19:0] m;
    logic [15:0] ra, rb;
    int idx;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_flags", out_flags, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    @(posedge clk); #1;

    drive(16'h3C00, 16'h3C00, 16'h3C00, 4'b0000, 1);
    drive(16'h3E00, 16'h4000, 16'h4200, 4'b0000, 1);
    drive(16'hC000, 16'h3800, 16'hBC00, 4'b0000, 1);
    drive(16'h3C01, 16'h3E00, 16'h3E02, 4'b0001, 1);
    drive(16'h3C01, 16'h3C01, 16'h3C02, 4'b0001, 1);
    drive(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101, 1);
    drive(16'h0400, 16'h3800, 16'h0000, 4'b0011, 1);
    drive(16'h8400, 16'h3800, 16'h8000, 4'b0011, 1);
    drive(16'h7C00, 16'h0000, 16'h7E00, 4'b1000, 1);
    drive(16'h7E00, 16'h3C00, 16'h7E00, 4'b0000, 1);
    drive(16'hFC00, 16'h4000, 16'hFC00, 4'b0000, 1);
    drive(16'h0001, 16'h4000, 16'h0000, 4'b0000, 1);
    drain();

    // Stall with full pipeline, then release and expect a 5-beat burst.
    out_ready = 1'b0; idx = 0;
    in_a = p5a[0]; in_b = p5b[0]; in_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        m = model(in_a, in_b);
        sb_push(m[15:0], m[19:16], 0);
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 5) begin in_a = p5a[idx]; in_b = p5b[idx]; end
    end
    check("stall_accepts", idx, 3);
    check("stall_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("burst_valid", out_valid, 1);
      if (in_valid && in_ready) begin
        m = model(in_a, in_b);
        sb_push(m[15:0], m[19:16], 0);
        idx++;
      end
      @(posedge clk); #1;
      if (idx >= 5) in_valid = 1'b0;
      else begin in_a = p5a[idx]; in_b = p5b[idx]; end
    end
    check("burst_count", idx, 5);
    drain();

    // Reset with three operations in flight.
    mon_en = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_a = 16'h4000; in_b = 16'h3C00; in_valid = 1'b1;
      @(negedge clk);
      check("preload_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("preload_full", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("flush_valid", out_valid, 0);
    check("flush_data", out_data, 0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stale", out_valid, 0);
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
    drive(16'h4000, 16'h4000, 16'h4400, 4'b0000, 1);
    drain();

    // Random operands under random backpressure.
    rnd_bp = 1'b1;
    for (int k = 0; k < 60; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 2 == 0) begin ra[14] = 1'b0; rb[14] = ~rb[13]; end
      m = model(ra, rb);
      drive(ra, rb, m[15:0], m[19:16], 0);
    end
    rnd_bp = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=0", sb.size());
    $fatal(1, "timeout");
  end

endmodule
